// File: rtl/noc_pkg.sv
// Shared NoC types: flit word, destination helper and NIC injector states.
// FLIT_DATA_WIDTH defaults to 32 unless the build defines it.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package noc_pkg;

    localparam int FLIT_W = `FLIT_DATA_WIDTH;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        STALL
    } nic_state_e;

    function automatic flit_t flit_dest(flit_t f, int id_bits);
        return f >> (FLIT_W - id_bits);
    endfunction

endpackage

// File: rtl/nic_sync_fifo.sv
// Packet FIFO for the NIC injector; power-of-two depth, wrapping pointers.
// Push when full and pop when empty are ignored.
module nic_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/noc_inject_nic.sv
// Credit-based flit injector into the local router port.
// Define NIC_STATS_EN to add flit and stall-cycle counters.
module noc_inject_nic
    import noc_pkg::*;
#(
    parameter int NUM_ROUTERS    = 16,
    parameter int ROUTER_ID      = 0,
    parameter int ROUTER_ID_BITS = $clog2(NUM_ROUTERS),
    parameter int NUM_VC         = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             core_valid,
    output logic                             core_ready,
    input  logic [ROUTER_ID_BITS-1:0]        core_dest,
    input  logic [FLIT_W-ROUTER_ID_BITS-1:0] core_payload,
    output logic [FLIT_W-1:0]                flit_data,
    output logic                             flit_valid,
    input  logic                             credit_inc,
    output logic [$clog2(NUM_VC+1)-1:0]      credit_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             credit_err
`ifdef NIC_STATS_EN
   ,output logic [31:0]                      stat_flits_sent,
    output logic [31:0]                      stat_stall_cycles
`endif
);

    localparam int CW = $clog2(NUM_VC+1);
    localparam int FW = $clog2(FIFO_DEPTH+1);

    if (ROUTER_ID >= NUM_ROUTERS) begin : g_bad_router_id
        $error("ROUTER_ID out of range");
    end

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          credit_drop;
    flit_t         head;
    logic [CW-1:0] credit_next;
    logic [FW-1:0] fifo_next;
    nic_state_e    state;

    assign core_ready  = !full;
    assign push        = core_valid && core_ready;
    assign pop         = !empty && (credit_count != '0);
    assign credit_drop = credit_inc && !pop
                      && (credit_count == CW'(NUM_VC));
    assign fifo_next   = fifo_count + FW'(push) - FW'(pop);

    always_comb begin
        credit_next = credit_count;
        if (pop && !credit_inc) begin
            credit_next = credit_count - 1'b1;
        end else if (credit_inc && !pop && !credit_drop) begin
            credit_next = credit_count + 1'b1;
        end
    end

    nic_sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({core_dest, core_payload}),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            flit_valid   <= 1'b0;
            flit_data    <= '0;
            credit_count <= CW'(NUM_VC);
            credit_err   <= 1'b0;
        end else begin
            flit_valid   <= pop;
            credit_count <= credit_next;
            if (pop) begin
                flit_data <= head;
            end
            if (credit_drop) begin
                credit_err <= 1'b1;
            end
        end
    end

    // State follows the counts; it never gates the pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (push) begin
                        state <= (credit_next == '0) ? STALL : SEND;
                    end
                end
                SEND: begin
                    if (fifo_next == '0) begin
                        state <= IDLE;
                    end else if (credit_next == '0) begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (credit_inc) begin
                        state <= SEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NIC_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_flits_sent   <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (pop && (stat_flits_sent != '1)) begin
                stat_flits_sent <= stat_flits_sent + 1'b1;
            end
            if ((state == STALL) && (stat_stall_cycles != '1)) begin
                stat_stall_cycles <= stat_stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule
